wb_trace_fifo: RTL and testbench

//   Captures every architectural register write retiring from the writeback stage
//   (RegWriteW, WriteRegW, resultW) into a first-word-fall-through FIFO.

---
 rtl/wb_trace_fifo.sv | 88 ++++++++
 tb/tb_wb_trace_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Trace FIFO for writeback-stage register writes: first-word-fall-through, sequence-tagged,
// drops on overflow (counted) so the pipeline is never stalled.
module wb_trace_fifo #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int DEPTH  = 16,
  parameter int SEQ_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWriteW,
  input  logic [REG_W-1:0]         WriteRegW,
  input  logic [DATA_W-1:0]        resultW,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REG_W-1:0]         out_reg,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic [SEQ_W-1:0]         ovf_cnt,
  input  logic                     ovf_clr
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [REG_W-1:0]  r_mem_reg  [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [SEQ_W-1:0]  r_mem_seq  [DEPTH];

  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [SEQ_W-1:0]  r_seq;
  logic [SEQ_W-1:0]  r_ovf_cnt;

  logic w_empty;
  logic w_full;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LVL_W'(DEPTH));
  assign w_push_req = RegWriteW && (WriteRegW != '0);
  assign w_pop      = !w_empty && out_ready;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;

  // Data storage carries no reset; stale slots are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_reg[r_wr_ptr]  <= WriteRegW;
      r_mem_data[r_wr_ptr] <= resultW;
      r_mem_seq[r_wr_ptr]  <= r_seq;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_level   <= '0;
      r_seq     <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
      else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
      if (w_push_req) r_seq <= r_seq + SEQ_W'(1);
      // A clear coinciding with a drop leaves exactly that one drop counted.
      if (ovf_clr)
        r_ovf_cnt <= w_drop ? SEQ_W'(1) : '0;
      else if (w_drop && (r_ovf_cnt != {SEQ_W{1'b1}}))
        r_ovf_cnt <= r_ovf_cnt + SEQ_W'(1);
    end
  end

  assign out_valid = !w_empty;
  assign out_reg   = w_empty ? '0 : r_mem_reg[r_rd_ptr];
  assign out_data  = w_empty ? '0 : r_mem_data[r_rd_ptr];
  assign out_seq   = w_empty ? '0 : r_mem_seq[r_rd_ptr];
  assign level     = r_level;
  assign full      = w_full;
  assign ovf_cnt   = r_ovf_cnt;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed scenarios plus random traffic, every cycle compared
// against a queue-based model of the trace FIFO.
module tb_wb_trace_fifo;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int DEPTH  = 16;
  localparam int SEQ_W  = 16;

  logic                  clk;
  logic                  rst;
  logic                  RegWriteW;
  logic [REG_W-1:0]      WriteRegW;
  logic [DATA_W-1:0]     resultW;
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_W-1:0]      out_reg;
  logic [DATA_W-1:0]     out_data;
  logic [SEQ_W-1:0]      out_seq;
  logic [$clog2(DEPTH):0] level;
  logic                  full;
  logic [SEQ_W-1:0]      ovf_cnt;
  logic                  ovf_clr;

  wb_trace_fifo #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .resultW(resultW),
    .out_valid(out_valid), .out_ready(out_ready), .out_reg(out_reg), .out_data(out_data),
    .out_seq(out_seq), .level(level), .full(full), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [REG_W-1:0]  r;
    logic [DATA_W-1:0] d;
    logic [SEQ_W-1:0]  s;
  } ent_t;

  ent_t             m_q[$];
  logic [SEQ_W-1:0] m_seq;
  logic [SEQ_W-1:0] m_ovf;
  int               n_checks;
  int               n_errors;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    check("level", 64'(level), 64'(m_q.size()));
    check("full", 64'(full), 64'(m_q.size() == DEPTH));
    check("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
    if (m_q.size() != 0) begin
      check("out_reg", 64'(out_reg), 64'(m_q[0].r));
      check("out_data", 64'(out_data), 64'(m_q[0].d));
      check("out_seq", 64'(out_seq), 64'(m_q[0].s));
    end else begin
      check("out_reg_empty", 64'(out_reg), 64'd0);
      check("out_data_empty", 64'(out_data), 64'd0);
      check("out_seq_empty", 64'(out_seq), 64'd0);
    end
  endtask

  // One clock: drive inputs, advance the model by the FIFO's rules, compare after the edge.
  task automatic step(input bit r, input bit rw, input logic [REG_W-1:0] wr,
                      input logic [DATA_W-1:0] wd, input bit rdy, input bit clr);
    bit   req, pop, drop, was_full;
    ent_t e;
    rst = r; RegWriteW = rw; WriteRegW = wr; resultW = wd; out_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    if (r) begin
      m_q.delete();
      m_seq = '0;
      m_ovf = '0;
    end else begin
      req      = rw && (wr != 0);
      was_full = (m_q.size() == DEPTH);
      pop      = (m_q.size() != 0) && rdy;
      drop     = req && was_full && !pop;
      if (pop) void'(m_q.pop_front());
      if (req && !drop) begin
        e.r = wr; e.d = wd; e.s = m_seq;
        m_q.push_back(e);
      end
      if (req) m_seq = m_seq + 1'b1;
      if (clr) m_ovf = drop ? SEQ_W'(1) : '0;
      else if (drop && m_ovf != {SEQ_W{1'b1}}) m_ovf = m_ovf + 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, '0, '0, rdy, 0);
  endtask

  task automatic write(input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] wd, input bit rdy);
    step(0, 1, wr, wd, rdy, 0);
  endtask

  task automatic do_reset();
    step(1, 1, 5'd3, 32'hdead_beef, 0, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_seq = '0; m_ovf = '0;
    rst = 1; RegWriteW = 1; WriteRegW = 5'd4; resultW = 32'h1; out_ready = 0; ovf_clr = 0;

    // Reset held two cycles with writes offered: nothing captured
    do_reset();
    do_reset();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(ovf_cnt), 64'd0);
    $display("reset: level=%0d valid=%0b", level, out_valid);

    // Single write becomes visible the cycle after the edge
    write(5'd8, 32'h0000_0005, 0);
    check("single_reg", 64'(out_reg), 64'd8);
    check("single_data", 64'(out_data), 64'd5);
    check("single_seq", 64'(out_seq), 64'd0);
    check("single_level", 64'(level), 64'd1);
    $display("single: reg=%0d data=%0h seq=%0d", out_reg, out_data, out_seq);

    // Writes to $0 are filtered and do not consume a sequence number
    do_reset();
    write(5'd0, 32'h1234, 0);
    check("zero_valid", 64'(out_valid), 64'd0);
    write(5'd9, 32'h55, 0);
    check("zero_next_seq", 64'(out_seq), 64'd0);
    check("zero_next_reg", 64'(out_reg), 64'd9);
    $display("filter: reg=%0d seq=%0d", out_reg, out_seq);

    // Overflow: 18 writes into 16 slots, then drain in order
    do_reset();
    for (int i = 0; i < 18; i++) write(5'(1 + i % 31), 32'(100 + i), 0);
    check("ovf_full", 64'(full), 64'd1);
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_cnt2", 64'(ovf_cnt), 64'd2);
    for (int i = 0; i < 16; i++) begin
      check("drain_seq", 64'(out_seq), 64'(i));
      $display("drain: reg=%0d data=%0d seq=%0d", out_reg, out_data, out_seq);
      idle(1);
    end
    check("drain_empty", 64'(out_valid), 64'd0);

    // Full with simultaneous push and pop: no drop, level held
    do_reset();
    for (int i = 0; i < 16; i++) write(5'd7, 32'(i), 0);
    write(5'd10, 32'hABCD, 1);
    check("fpp_level", 64'(level), 64'd16);
    check("fpp_ovf", 64'(ovf_cnt), 64'd0);
    check("fpp_head_seq", 64'(out_seq), 64'd1);
    while (m_q.size() != 0) idle(1);
    $display("full push+pop: drained, ovf=%0d", ovf_cnt);

    // Reset mid-drain discards contents and restarts sequence numbering
    do_reset();
    for (int i = 0; i < 5; i++) write(5'd12, 32'(i), 0);
    idle(1);
    idle(1);
    do_reset();
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_level", 64'(level), 64'd0);
    write(5'd13, 32'h77, 0);
    check("mid_rst_seq", 64'(out_seq), 64'd0);
    $display("mid-drain reset: next seq=%0d", out_seq);

    // Clear coinciding with a drop
    do_reset();
    for (int i = 0; i < 19; i++) write(5'd2, 32'(i), 0);
    step(0, 1, 5'd2, 32'h99, 0, 1);
    check("clr_drop", 64'(ovf_cnt), 64'd1);
    step(0, 0, '0, '0, 0, 1);
    check("clr_only", 64'(ovf_cnt), 64'd0);
    $display("clear+drop: ovf=1 then 0");

    // Saturation of the drop counter and sequence wrap
    for (int i = 0; i < 65540; i++) write(5'd6, 32'(i), 0);
    check("ovf_sat", 64'(ovf_cnt), 64'hFFFF);
    $display("saturation: ovf=%0h", ovf_cnt);
    while (m_q.size() != 0) idle(1);
    write(5'd6, 32'h1, 0);
    $display("post-wrap write: seq=%0d", out_seq);

    // Random traffic with varying consumer pressure
    for (int i = 0; i < 4000; i++) begin
      bit rdy;
      case ((i / 500) % 3)
        0:       rdy = ($urandom % 4) == 0;
        1:       rdy = ($urandom % 4) != 0;
        default: rdy = ($urandom % 2) == 0;
      endcase
      step(($urandom % 300) == 0, ($urandom % 4) != 0, 5'($urandom % 32), $urandom,
           rdy, ($urandom % 60) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
